rat_intr_ctrl: RTL and testbench
================================

# rat_intr_ctrl

Eight-source interrupt controller for the RAT MCU. It sits in the wrapper between peripheral event sources (debounced buttons, timers, UART flags) and the MCU's single `INTV` input. It latches rising edges into a pending register and gates them with a software-written mask. It drives a fixed-width interrupt pulse and holds off further requests until the ISR acknowledges through the MCU I/O port space.

## Interface
Parameters:
- `MASK_ID`, 8'h30: port ID; write sets the mask register, read returns the mask.
- `STATUS_ID`, 8'h31: port ID; read returns pending & mask. Writes are ignored.
- `VECTOR_ID`, 8'h32: port ID; read returns the highest-priority active source index. Writes are ignored.
- `ACK_ID`, 8'h33: port ID; write-1-to-clear pending bits and acknowledge the interrupt. Reads return 0.
- `INTV_LEN`, 4: `INTV` pulse width in clock cycles. Legal range is 1..15.

Ports:
- `CLK`  in  1  MCU clock. All state is on the rising edge.
- `RESET`  in  1  Synchronous, active-high reset.
- `IRQ`  in  8  Source request lines, synchronous to `CLK`. Only rising edges matter.
- `PORT_ID`  in  8  MCU port ID.
- `OUT_PORT`  in  8  MCU write data.
- `IO_STRB`  in  1  MCU write strobe.
- `IN_DATA`  out  8  Read data. It is 8'h00 when `PORT_ID` matches none of the block's IDs. The wrapper ORs it into the input mux.
- `IN_SEL`  out  1  High when `PORT_ID` equals `MASK_ID`, `STATUS_ID` or `VECTOR_ID`.
- `INTV`  out  1  Interrupt request to the MCU.

## Operation
- Registers:
  - `irq_prev[7:0]` holds the previous `IRQ` sample.
  - `pending[7:0]` holds latched events.
  - `mask[7:0]` holds the enables; 1 means enabled.
  - `cnt[3:0]` is the pulse counter.
  - `ack_seen` is a 1-bit flag.
  - The FSM state register.
- Edge detect: `rise = IRQ & ~irq_prev`. `irq_prev <= IRQ` every cycle.
- Pending update each cycle: `pending <= (pending & ~clr) | rise`.
  - `clr = OUT_PORT` when `IO_STRB` is high and `PORT_ID == ACK_ID`; otherwise `clr = 0`.
  - If a new rise and a clear hit the same bit in the same cycle, the set wins.
- Mask write: when `IO_STRB` is high and `PORT_ID == MASK_ID`, `mask <= OUT_PORT`.
  - Masking never clears pending bits.
  - Unmasking a pending bit makes it active immediately.
- `active = pending & mask`.
- Vector: lowest set index of `active` (bit 0 has the highest priority), returned as {5'b0, idx}. Returns 8'hFF when `active` is 0.
- Reads are combinational from `PORT_ID` with no read side effects.
- FSM:
  - IDLE: `INTV` = 0. If `active` != 0, go to PULSE, `cnt <= 0`, `ack_seen <= 0`.
  - PULSE: `INTV` = 1, `cnt` increments. Any ACK write sets `ack_seen`. When `cnt == INTV_LEN-1`, go to IDLE if `ack_seen` or an ACK is happening this cycle; otherwise go to SERVICE.
  - SERVICE: `INTV` = 0. Any ACK write (any data value) moves the FSM to IDLE.
- After returning to IDLE, remaining or new active bits re-trigger on the next cycle, so back-to-back interrupts are separated by at least one idle cycle.
- A mask write that clears all active bits in PULSE or SERVICE does not abort the sequence; only an ACK ends it.
- Reset values:
  - `pending`, `mask`, `irq_prev`, `cnt`, `ack_seen` = 0.
  - State = IDLE.
  - `INTV` = 0, `IN_SEL` = 0 if `PORT_ID` is unmatched, `IN_DATA` = 0.
- A line held high through reset registers one rise on the first cycle after reset.
- Reset asserted mid-PULSE drops `INTV` on the next edge and clears all state.

## Timing
- Rise-to-pending: `IRQ` high at edge k with `irq_prev` = 0 → `pending` bit set after edge k.
- Pending-to-INTV: FSM enters PULSE at edge k+1; `INTV` is high after edge k+1 for exactly `INTV_LEN` cycles.
- ACK in SERVICE at edge m → IDLE after m. A still-active source re-enters PULSE at edge m+1.
- Mask and ACK writes take effect at the strobed edge. Reads are valid in the same cycle `PORT_ID` is presented.
- `INTV` is a decode of the registered state: glitch-free and one cycle per state.

## Test plan
- Reset, then `mask`=8'h01, pulse `IRQ[0]` one cycle → `INTV` high for 4 cycles starting 2 edges after the `IRQ` edge; STATUS reads 8'h01; VECTOR reads 8'h00; ACK with 8'h01 → STATUS reads 8'h00, FSM IDLE, no re-trigger.
- `mask`=8'h00, pulse `IRQ[3]` → no `INTV`, STATUS reads 8'h00; write `mask`=8'h08 → `INTV` pulse begins the cycle after the write; VECTOR reads 8'h03.
- `mask`=8'hFF, `IRQ[5]` and `IRQ[2]` rise together → VECTOR reads 8'h02; ACK 8'h04 → one idle cycle, second `INTV` pulse, VECTOR reads 8'h05; ACK 8'h20 → IDLE, VECTOR reads 8'hFF.
- ACK write of 8'h01 issued during the 2nd PULSE cycle with `IRQ[0]` pending → pulse completes the full 4 cycles, FSM goes directly to IDLE, no SERVICE state.
- `IRQ[1]` re-rises in the same cycle as ACK 8'h02 → bit 1 stays pending; a new `INTV` pulse follows one idle cycle later.
- `RESET` asserted on the 2nd PULSE cycle → `INTV` = 0 after that edge; `mask`/`pending` read 8'h00. With `IRQ[7]` held high through reset, STATUS shows bit 7 pending (after unmasking) after the first post-reset edge.

Source files
------------

// File: rtl/rat_intr_ctrl.sv
// Eight-source interrupt controller for the RAT MCU: edge-latched pending bits,
// a software mask, a fixed-width INTV pulse, and an ACK handshake over the port space.
module rat_intr_ctrl #(
  parameter logic [7:0] MASK_ID   = 8'h30,
  parameter logic [7:0] STATUS_ID = 8'h31,
  parameter logic [7:0] VECTOR_ID = 8'h32,
  parameter logic [7:0] ACK_ID    = 8'h33,
  parameter int         INTV_LEN  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IRQ,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_DATA,
  output logic       IN_SEL,
  output logic       INTV
);

  typedef enum logic [1:0] {IDLE, PULSE, SERVICE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(INTV_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] irq_prev_q, irq_prev_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ack_seen_q, ack_seen_d;
  logic       intv_q, intv_d;

  logic [7:0] rise, clr, active, vector;
  logic       ack_wr, mask_wr;

  always_comb begin
    rise       = IRQ & ~irq_prev_q;
    irq_prev_d = IRQ;
    ack_wr     = IO_STRB && (PORT_ID == ACK_ID);
    mask_wr    = IO_STRB && (PORT_ID == MASK_ID);
    clr        = ack_wr ? OUT_PORT : 8'h00;
    // OR-ing the rise in last lets a same-cycle new event beat the clear
    pending_d  = (pending_q & ~clr) | rise;
    mask_d     = mask_wr ? OUT_PORT : mask_q;
    active     = pending_q & mask_q;
  end

  // Lowest index wins; 8'hFF signals that nothing is active
  always_comb begin
    vector = 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) vector = {5'b0, 3'(i)};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_seen_d = ack_seen_q;
    unique case (state_q)
      IDLE: begin
        if (active != 8'h00) begin
          state_d    = PULSE;
          cnt_d      = 4'd0;
          ack_seen_d = 1'b0;
        end
      end
      PULSE: begin
        cnt_d      = cnt_q + 4'd1;
        ack_seen_d = ack_seen_q | ack_wr;
        if (cnt_q == CNT_LAST) state_d = (ack_seen_q || ack_wr) ? IDLE : SERVICE;
      end
      SERVICE: begin
        if (ack_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    intv_d = (state_d == PULSE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      irq_prev_q <= 8'h00;
      pending_q  <= 8'h00;
      mask_q     <= 8'h00;
      cnt_q      <= 4'd0;
      ack_seen_q <= 1'b0;
      intv_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      ack_seen_q <= ack_seen_d;
      intv_q     <= intv_d;
    end
  end

  // Read path is purely combinational and has no side effects on state
  always_comb begin
    IN_DATA = 8'h00;
    IN_SEL  = 1'b0;
    if (PORT_ID == MASK_ID) begin
      IN_DATA = mask_q;
      IN_SEL  = 1'b1;
    end else if (PORT_ID == STATUS_ID) begin
      IN_DATA = active;
      IN_SEL  = 1'b1;
    end else if (PORT_ID == VECTOR_ID) begin
      IN_DATA = vector;
      IN_SEL  = 1'b1;
    end
  end

  assign INTV = intv_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed testbench for rat_intr_ctrl: pulse timing, masking, priority,
// early/late ACK, set-beats-clear, and reset behaviour.
module tb_rat_intr_ctrl;

  localparam logic [7:0] MASK_ID   = 8'h30;
  localparam logic [7:0] STATUS_ID = 8'h31;
  localparam logic [7:0] VECTOR_ID = 8'h32;
  localparam logic [7:0] ACK_ID    = 8'h33;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] IRQ;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_DATA;
  logic       IN_SEL;
  logic       INTV;

  int total = 0;
  int bad   = 0;

  rat_intr_ctrl #(
    .MASK_ID(MASK_ID), .STATUS_ID(STATUS_ID), .VECTOR_ID(VECTOR_ID),
    .ACK_ID(ACK_ID), .INTV_LEN(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .IN_DATA(IN_DATA),
    .IN_SEL(IN_SEL), .INTV(INTV)
  );

  always #5 CLK = ~CLK;

  // Advance one clock and land 1 time unit past the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [7:0] id, input logic [7:0] exp);
    PORT_ID = id;
    #1;
    check_output(tag, IN_DATA, exp);
    PORT_ID = 8'h00;
  endtask

  task automatic port_write(input logic [7:0] id, input logic [7:0] data);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    tick();
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
  endtask

  // Called just after the edge that entered PULSE; verifies 4 high cycles then low
  task automatic pulse_then_service(input string tag);
    check_output({tag, "_p0"}, {7'b0, INTV}, 8'h01);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_output($sformatf("%s_p%0d", tag, i), {7'b0, INTV}, 8'h01);
    end
    tick();
    check_output({tag, "_svc"}, {7'b0, INTV}, 8'h00);
  endtask

  initial begin
    RESET = 1'b1; IRQ = 8'h00; PORT_ID = 8'h00; OUT_PORT = 8'h00; IO_STRB = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    check_output("rst_intv", {7'b0, INTV}, 8'h00);
    check_output("rst_insel_unmatched", {7'b0, IN_SEL}, 8'h00);
    check_output("rst_indata_unmatched", IN_DATA, 8'h00);
    read_check("rst_mask", MASK_ID, 8'h00);
    read_check("rst_status", STATUS_ID, 8'h00);
    read_check("rst_vector", VECTOR_ID, 8'hFF);

    // Basic single-source interrupt
    port_write(MASK_ID, 8'h01);
    read_check("t1_mask", MASK_ID, 8'h01);
    PORT_ID = MASK_ID; #1;
    check_output("t1_insel_mask", {7'b0, IN_SEL}, 8'h01);
    PORT_ID = 8'h00;
    IRQ = 8'h01;
    tick();
    IRQ = 8'h00;
    check_output("t1_intv_after_irq_edge", {7'b0, INTV}, 8'h00);
    read_check("t1_status", STATUS_ID, 8'h01);
    tick();
    read_check("t1_vector", VECTOR_ID, 8'h00);
    pulse_then_service("t1");
    tick();
    check_output("t1_svc_hold", {7'b0, INTV}, 8'h00);
    PORT_ID = ACK_ID; #1;
    check_output("t1_ack_read_zero", IN_DATA, 8'h00);
    check_output("t1_ack_insel", {7'b0, IN_SEL}, 8'h00);
    port_write(ACK_ID, 8'h01);
    read_check("t1_status_cleared", STATUS_ID, 8'h00);
    tick();
    tick();
    check_output("t1_no_retrigger", {7'b0, INTV}, 8'h00);

    // Masked source, then unmask
    port_write(MASK_ID, 8'h00);
    IRQ = 8'h08;
    tick();
    IRQ = 8'h00;
    tick();
    check_output("t2_masked_intv", {7'b0, INTV}, 8'h00);
    read_check("t2_masked_status", STATUS_ID, 8'h00);
    port_write(MASK_ID, 8'h08);
    check_output("t2_intv_at_write", {7'b0, INTV}, 8'h00);
    read_check("t2_status", STATUS_ID, 8'h08);
    tick();
    read_check("t2_vector", VECTOR_ID, 8'h03);
    pulse_then_service("t2");
    port_write(ACK_ID, 8'h08);
    read_check("t2_status_cleared", STATUS_ID, 8'h00);

    // Two simultaneous sources, priority order
    port_write(MASK_ID, 8'hFF);
    IRQ = 8'h24;
    tick();
    IRQ = 8'h00;
    tick();
    read_check("t3_vector_first", VECTOR_ID, 8'h02);
    pulse_then_service("t3a");
    port_write(ACK_ID, 8'h04);
    check_output("t3_idle_gap", {7'b0, INTV}, 8'h00);
    tick();
    read_check("t3_vector_second", VECTOR_ID, 8'h05);
    pulse_then_service("t3b");
    port_write(ACK_ID, 8'h20);
    tick();
    check_output("t3_idle", {7'b0, INTV}, 8'h00);
    read_check("t3_vector_none", VECTOR_ID, 8'hFF);

    // Early ACK during the pulse skips SERVICE
    IRQ = 8'h01;
    tick();
    IRQ = 8'h00;
    tick();
    check_output("t4_p0", {7'b0, INTV}, 8'h01);
    tick();
    check_output("t4_p1", {7'b0, INTV}, 8'h01);
    port_write(ACK_ID, 8'h01);
    check_output("t4_p2", {7'b0, INTV}, 8'h01);
    tick();
    check_output("t4_p3", {7'b0, INTV}, 8'h01);
    tick();
    check_output("t4_idle", {7'b0, INTV}, 8'h00);
    read_check("t4_status", STATUS_ID, 8'h00);
    tick();
    check_output("t4_no_retrigger", {7'b0, INTV}, 8'h00);

    // Re-rise in the same cycle as its clear: set wins
    IRQ = 8'h02;
    tick();
    IRQ = 8'h00;
    tick();
    pulse_then_service("t5");
    IRQ = 8'h02;
    port_write(ACK_ID, 8'h02);
    IRQ = 8'h00;
    check_output("t5_idle_gap", {7'b0, INTV}, 8'h00);
    read_check("t5_status_kept", STATUS_ID, 8'h02);
    tick();
    check_output("t5_repulse", {7'b0, INTV}, 8'h01);

    // Reset on the second pulse cycle, IRQ[7] held through reset
    tick();
    check_output("t6_p1", {7'b0, INTV}, 8'h01);
    RESET = 1'b1;
    IRQ   = 8'h80;
    tick();
    check_output("t6_rst_intv", {7'b0, INTV}, 8'h00);
    read_check("t6_rst_mask", MASK_ID, 8'h00);
    read_check("t6_rst_status", STATUS_ID, 8'h00);
    tick();
    RESET = 1'b0;
    tick();
    read_check("t6_status_masked", STATUS_ID, 8'h00);
    port_write(MASK_ID, 8'hFF);
    read_check("t6_status_bit7", STATUS_ID, 8'h80);
    read_check("t6_vector_bit7", VECTOR_ID, 8'h07);
    check_output("t6_intv_pre", {7'b0, INTV}, 8'h00);
    tick();
    check_output("t6_intv_pulse", {7'b0, INTV}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
